icetap_rle: RTL and testbench
=============================

# icetap_rle

Run-length encoder that sits directly upstream of the capture RAM stage in the src_clk domain. It compresses the raw probe vector into (value, repeat-count) records, so the RAM holds transitions rather than every cycle. Its output record feeds the capture stage's signals_in and store qualification. Recording depth in time therefore grows by up to 2^CNT_BITS per RAM entry.

## Interface
Parameters:
- NR_SIGNALS, 16, width of probed vector
- CNT_BITS, 8, width of repeat counter; a run holds at most 2^CNT_BITS samples

Ports:
- src_clk  in  1  sampling clock, all logic rising-edge
- src_reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- enable  in  1  level; high = encoding active
- flush  in  1  pulse; force-close current run
- signals_in  in  NR_SIGNALS  raw probe sample, one per cycle
- out_valid  out  1  record available
- out_ready  in  1  downstream accepts record this cycle
- out_signals  out  NR_SIGNALS  run value
- out_count  out  CNT_BITS  extra repeats; run length = out_count+1
- overflow  out  1  sticky: a record was dropped

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE, enable=1: latch signals_in as cur_val, cur_cnt=0, clear overflow, go RUN. Nothing emitted.
- RUN, enable=1, each cycle with sample s:
  - s==cur_val, cur_cnt<max, flush=0: cur_cnt++.
  - s!=cur_val, or cur_cnt==max (2^CNT_BITS-1), or flush=1: emit (cur_val, cur_cnt); cur_val=s, cur_cnt=0.
- RUN, enable=0: emit (cur_val, cur_cnt), go IDLE; that cycle's sample is ignored.
- Emit: if out_valid==0 or out_ready==1, load the output register and set out_valid=1. Otherwise keep the held record, discard the new one, and set overflow=1.
- out_valid&&out_ready with no emit: out_valid->0 next cycle.
- overflow is cleared only by src_reset or the IDLE->RUN transition.
- Counter never wraps; saturation always closes the run.
- flush in IDLE: no effect.
- flush together with s!=cur_val: a single emit.

## Timing
- Reset values: out_valid=0, out_signals=0, out_count=0, overflow=0, state IDLE, cur_val=0, cur_cnt=0.
- A closing sample at cycle N yields out_valid=1 with the closed run at cycle N+1.
- Enable falling at cycle N yields the final record at N+1.
- Throughput: one record per cycle sustained when out_ready=1.
- out_signals/out_count are stable while out_valid=1 and out_ready=0.
- src_reset asserted mid-run: the run and the held record are discarded, and all outputs return to reset values next cycle.

## Configuration
- ICETAP_RLE_SYNC_EN defined: signals_in passes through a two-flop synchronizer (reset to 0) before comparison. Every latency above increases by 2 cycles. enable and flush are delayed by 2 cycles to stay aligned with the samples.
- Not defined: signals_in is used directly, with latencies as stated.

## Structure
- Package icetap_rle_pkg: state encoding (IDLE=1'b0, RUN=1'b1) and function cnt_max(CNT_BITS).
- Sub-module icetap_sync2 (parameterized width, synchronous active-high reset) instantiated only under ICETAP_RLE_SYNC_EN.
- Rest is one always block for the state/run registers plus one for the output register.

## Test plan
- Constant run: enable at cycle 0, signals_in=16'hA5A5 for 10 cycles, then 16'h0001 -> one record {A5A5, count 9} at cycle 11.
- Saturation: CNT_BITS=8, constant 16'h0000 for 600 cycles -> records {0,255},{0,255} are emitted, then disable -> {0,87}.
- Back-pressure: out_ready=0, values alternate every cycle -> first record held unchanged, overflow=1 after the second emit; re-enable clears overflow.
- Simultaneous accept+emit: out_valid=1, out_ready=1, new emit same cycle -> out_valid stays 1 with the new record, no overflow.
- Flush: 5 cycles of 16'h1234, flush on the 6th equal sample -> {1234, 4} emitted, new run starts at count 0.
- Reset mid-run: src_reset pulse during a 20-cycle run -> all outputs 0 next cycle, no record emitted; with ICETAP_RLE_SYNC_EN defined, the first test's record appears at cycle 13.

Source files
------------

// File: rtl/icetap_rle_pkg.sv
// icetap_rle_pkg
//   Shared definitions for the icetap run-length encoder:
//   - state_e : encoder state encoding (IDLE / RUN)
//   - cnt_max : largest value a CNT_BITS-wide repeat counter may hold
package icetap_rle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // All-ones value of a cnt_bits-wide counter; a run closes when it is reached
  // so the counter never wraps.
  function automatic logic [31:0] cnt_max(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/icetap_sync2.sv
// icetap_sync2
//   Two-flop synchronizer, both stages cleared by a synchronous reset.
//   Ports:
//     clk   in          sampling clock
//     srst  in          synchronous active-high reset
//     d_i   in  WIDTH   asynchronous / foreign-domain input
//     q_o   out WIDTH   input delayed by two clk cycles
module icetap_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/icetap_rle.sv
// icetap_rle
//   Run-length encoder in front of the capture RAM. Compresses the probe
//   vector into (value, extra-repeat count) records; a run is closed by a
//   value change, counter saturation, a flush pulse or enable falling.
//   Output is a single-entry register with valid/ready; a record that cannot
//   be loaded because the held one is not accepted is dropped and flagged in
//   the sticky overflow bit.
//
//   Optional build macro ICETAP_RLE_SYNC_EN: signals_in, enable and flush go
//   through a two-flop synchronizer first (all latencies +2 cycles).
//
//   Ports:
//     src_clk      in   1           sampling clock (rising edge)
//     src_reset    in   1           synchronous active-high reset
//     enable       in   1           level, encoding active
//     flush        in   1           pulse, force-close current run
//     signals_in   in   NR_SIGNALS  raw probe sample
//     out_valid    out  1           record available
//     out_ready    in   1           downstream accepts record
//     out_signals  out  NR_SIGNALS  run value
//     out_count    out  CNT_BITS    extra repeats (run length = count+1)
//     overflow     out  1           sticky: a record was dropped
module icetap_rle
  import icetap_rle_pkg::*;
#(
  parameter int NR_SIGNALS = 16,
  parameter int CNT_BITS   = 8
) (
  input  logic                  src_clk,
  input  logic                  src_reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [NR_SIGNALS-1:0] signals_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NR_SIGNALS-1:0] out_signals,
  output logic [CNT_BITS-1:0]   out_count,
  output logic                  overflow
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Sample-aligned controls and data seen by the encoder
  logic                  en_s;
  logic                  fl_s;
  logic [NR_SIGNALS-1:0] samp_s;

`ifdef ICETAP_RLE_SYNC_EN
  // enable/flush ride through the same synchronizer so they stay aligned
  // with the sample they qualify.
  icetap_sync2 #(
    .WIDTH(NR_SIGNALS + 2)
  ) u_sync (
    .clk  (src_clk),
    .srst (src_reset),
    .d_i  ({enable, flush, signals_in}),
    .q_o  ({en_s, fl_s, samp_s})
  );
`else
  assign en_s   = enable;
  assign fl_s   = flush;
  assign samp_s = signals_in;
`endif

  // Run tracking
  state_e                state_q, state_d;
  logic [NR_SIGNALS-1:0] cur_val_q, cur_val_d;
  logic [CNT_BITS-1:0]   cur_cnt_q, cur_cnt_d;
  logic                  emit;
  logic                  clr_ovf;

  always_comb begin
    state_d   = state_q;
    cur_val_d = cur_val_q;
    cur_cnt_d = cur_cnt_q;
    emit      = 1'b0;
    clr_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d   = RUN;
          cur_val_d = samp_s;
          cur_cnt_d = '0;
          clr_ovf   = 1'b1;
        end
      end
      RUN: begin
        if (!en_s) begin
          // Final record; this cycle's sample is not part of any run.
          emit    = 1'b1;
          state_d = IDLE;
        end else if ((samp_s != cur_val_q) || (cur_cnt_q == CNT_MAX) || fl_s) begin
          // Close the run and start a new one with the current sample.
          emit      = 1'b1;
          cur_val_d = samp_s;
          cur_cnt_d = '0;
        end else begin
          cur_cnt_d = cur_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state_q   <= IDLE;
      cur_val_q <= '0;
      cur_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      cur_cnt_q <= cur_cnt_d;
    end
  end

  // Output register
  logic                  out_valid_q, out_valid_d;
  logic [NR_SIGNALS-1:0] out_sig_q, out_sig_d;
  logic [CNT_BITS-1:0]   out_cnt_q, out_cnt_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sig_d   = out_sig_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      // The slot is free if empty or being drained this very cycle.
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_sig_d   = cur_val_q;
        out_cnt_d   = cur_cnt_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      out_valid_q <= 1'b0;
      out_sig_q   <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sig_q   <= out_sig_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_signals = out_sig_q;
  assign out_count   = out_cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_icetap_rle.sv
// tb_icetap_rle
//   Self-checking bench for icetap_rle (NR_SIGNALS=16, CNT_BITS=8).
//   Expected records are queued as stimulus is driven and compared in order
//   as the DUT hands them off (out_valid && out_ready).
module tb_icetap_rle;

`ifdef ICETAP_RLE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        src_clk;
  logic        src_reset;
  logic        enable;
  logic        flush;
  logic [15:0] signals_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_signals;
  logic [7:0]  out_count;
  logic        overflow;

  icetap_rle #(
    .NR_SIGNALS(16),
    .CNT_BITS  (8)
  ) dut (
    .src_clk    (src_clk),
    .src_reset  (src_reset),
    .enable     (enable),
    .flush      (flush),
    .signals_in (signals_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_signals(out_signals),
    .out_count  (out_count),
    .overflow   (overflow)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample, advance past the sampling edge.
  task automatic step(input logic [15:0] s, input logic en, input logic fl);
    signals_in = s;
    enable     = en;
    flush      = fl;
    @(posedge src_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic expect_rec(input logic [15:0] v, input logic [7:0] c);
    sb_q.push_back({v, c});
  endtask

  // Monitor: a record is consumed on every edge where valid and ready are high.
  always @(negedge src_clk) begin
    if (!src_reset && out_valid && out_ready) begin
      logic [23:0] exp;
      check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        $display("rec value=%04h count=%0d (exp value=%04h count=%0d)",
                 out_signals, out_count, exp[23:8], exp[7:0]);
        check_eq("rec_value", 32'(out_signals), 32'(exp[23:8]));
        check_eq("rec_count", 32'(out_count), 32'(exp[7:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    src_reset  = 1'b1;
    enable     = 1'b0;
    flush      = 1'b0;
    signals_in = 16'h0;
    out_ready  = 1'b1;
    repeat (3) @(posedge src_clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_signals", 32'(out_signals), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    src_reset = 1'b0;
    idle(2);

    // Constant run with record timing
    expect_rec(16'hA5A5, 8'd9);
    for (int k = 0; k < 12 + LAT; k++) begin
      step((k < 10) ? 16'hA5A5 : 16'h0001, 1'b1, 1'b0);
      check_eq($sformatf("const_valid_k%0d", k), 32'(out_valid), 32'(k == 10 + LAT));
    end
    expect_rec(16'h0001, 8'(1 + LAT));
    idle(LAT + 3);
    check_eq("const_drained", 32'(sb_q.size()), 32'd0);

    // Saturation
    expect_rec(16'h0000, 8'd255);
    expect_rec(16'h0000, 8'd255);
    expect_rec(16'h0000, 8'd87);
    for (int k = 0; k < 600; k++) step(16'h0000, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("sat_drained", 32'(sb_q.size()), 32'd0);
    check_eq("sat_overflow", 32'(overflow), 32'd0);

    // Back-pressure: first record held, later ones dropped
    out_ready = 1'b0;
    expect_rec(16'h1111, 8'd0);
    for (int k = 0; k < 6; k++) step(k[0] ? 16'h2222 : 16'h1111, 1'b1, 1'b0);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_held_value", 32'(out_signals), 32'h1111);
    check_eq("bp_held_count", 32'(out_count), 32'd0);
    check_eq("bp_overflow", 32'(overflow), 32'd1);
    idle(LAT + 2);
    check_eq("bp_stable_value", 32'(out_signals), 32'h1111);
    out_ready = 1'b1;
    idle(2);
    check_eq("bp_valid_after_accept", 32'(out_valid), 32'd0);
    check_eq("bp_overflow_sticky", 32'(overflow), 32'd1);
    expect_rec(16'h5555, 8'd0);
    step(16'h5555, 1'b1, 1'b0);
    idle(LAT);
    check_eq("bp_overflow_cleared", 32'(overflow), 32'd0);
    idle(3);
    check_eq("bp_drained", 32'(sb_q.size()), 32'd0);

    // Simultaneous accept and emit every cycle
    for (int k = 0; k < 8; k++) expect_rec(k[0] ? 16'h0055 : 16'h00AA, 8'd0);
    for (int k = 0; k < 8; k++) begin
      step(k[0] ? 16'h0055 : 16'h00AA, 1'b1, 1'b0);
      if (k >= 1 + LAT) check_eq($sformatf("tp_valid_k%0d", k), 32'(out_valid), 32'd1);
    end
    idle(LAT + 3);
    check_eq("tp_overflow", 32'(overflow), 32'd0);
    check_eq("tp_drained", 32'(sb_q.size()), 32'd0);

    // Flush: no effect in IDLE, closes the run in RUN
    step(16'h0000, 1'b0, 1'b1);
    idle(LAT + 1);
    check_eq("flush_idle_valid", 32'(out_valid), 32'd0);
    expect_rec(16'h1234, 8'd4);
    expect_rec(16'h1234, 8'd3);
    for (int k = 0; k < 9; k++) step(16'h1234, 1'b1, 1'b1 ? (k == 5) : 1'b0);
    idle(LAT + 3);
    check_eq("flush_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-run discards the held record and the overflow flag
    out_ready = 1'b0;
    for (int k = 0; k < 15 + LAT; k++)
      step((k < 3) ? 16'h7777 : ((k < 13) ? 16'h8888 : 16'h9999), 1'b1, 1'b0);
    check_eq("mr_valid_before", 32'(out_valid), 32'd1);
    check_eq("mr_value_before", 32'(out_signals), 32'h7777);
    check_eq("mr_overflow_before", 32'(overflow), 32'd1);
    src_reset = 1'b1;
    @(posedge src_clk);
    #1;
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    check_eq("mr_signals", 32'(out_signals), 32'd0);
    check_eq("mr_count", 32'(out_count), 32'd0);
    check_eq("mr_overflow", 32'(overflow), 32'd0);
    src_reset = 1'b0;
    out_ready = 1'b1;
    idle(LAT + 3);
    check_eq("mr_no_record", 32'(out_valid), 32'd0);
    check_eq("final_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
